// File: rtl/mmio_arbiter_pkg.sv
// Shared types and constants for the two-master mmio arbiter.
// Holds the FSM encoding, the mmio base address and an address helper.
package mmio_arbiter_pkg;

    // Lowest real byte address decoded by the mmio block.
    localparam logic [15:0] MMIO_BASE = 16'hFF00;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RD_WAIT = 2'd2
    } arb_state_e;

    // Real byte address seen by mmio: word address shifted, byte select in bit 0.
    function automatic logic [15:0] real_addr(
        input logic [15:0] addr,
        input logic        bsel
    );
        return {addr[14:0], bsel};
    endfunction

endpackage

// File: rtl/mmio_rr_pick.sv
// Two-way round-robin picker for the mmio arbiter.
// Ports: elig[1:0] eligible masters, last_grant; gnt_valid, gnt_id out.
module mmio_rr_pick (
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // On a tie the master that did not win last time gets the grant.
    always_comb begin
        gnt_valid = |elig;
        gnt_id    = elig[1] & (~elig[0] | ~last_grant);
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Shares one mmio port between the CPU LSU (master 0) and the UART loader
// (master 1). Ports: req/we/addr/bsel/wdata in and ack/rdata/err out per
// master; m_en/m_we/m_bsel/m_addr/m_wdata out, m_rdata/m_serviced in.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic        bsel0,
    input  logic        bsel1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        m_en,
    output logic        m_we,
    output logic        m_bsel,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_serviced
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [15:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              m_en_q, m_en_d, m_we_q, m_we_d;
    logic              m_bsel_q, m_bsel_d;
    logic [15:0]       m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;

    logic [1:0]        elig;
    logic              gnt_valid, gnt_id;
    logic              fin, fin_rd, fin_err;
    logic [15:0]       fin_data;

    // A master is masked during its own ack cycle so a still-held req
    // does not start a second transfer.
    assign elig = {req1 & ~ack1_q, req0 & ~ack0_q};

    mmio_rr_pick u_pick (
        .elig       (elig),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:    if (gnt_valid) state_d = ARB_ISSUE;
            ARB_ISSUE:   state_d = we_q ? ARB_IDLE : ARB_RD_WAIT;
            ARB_RD_WAIT: if (m_serviced || cnt_q == CNT_LAST) state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    // Output flops are loaded one cycle early so every port is registered:
    // the mmio strobe is set on the grant edge, acks on the completion edge.
    always_comb begin
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = err0_q;
        err1_d       = err1_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        m_en_d       = 1'b0;
        m_we_d       = 1'b0;
        m_bsel_d     = 1'b0;
        m_addr_d     = 16'h0;
        m_wdata_d    = 16'h0;
        fin          = 1'b0;
        fin_rd       = 1'b0;
        fin_err      = 1'b0;
        fin_data     = 16'h0;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    id_d         = gnt_id;
                    we_d         = gnt_id ? we1 : we0;
                    last_grant_d = gnt_id;
                    m_en_d       = 1'b1;
                    m_we_d       = gnt_id ? we1 : we0;
                    m_bsel_d     = gnt_id ? bsel1 : bsel0;
                    m_addr_d     = gnt_id ? addr1 : addr0;
                    m_wdata_d    = gnt_id ? wdata1 : wdata0;
                end
            end
            ARB_ISSUE: begin
                cnt_d = '0;
                fin   = we_q;
            end
            ARB_RD_WAIT: begin
                if (m_serviced) begin
                    fin      = 1'b1;
                    fin_rd   = 1'b1;
                    fin_data = m_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    fin     = 1'b1;
                    fin_rd  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (fin) begin
            if (id_q) begin
                ack1_d = 1'b1;
                err1_d = fin_err;
                if (fin_rd) rdata1_d = fin_data;
            end else begin
                ack0_d = 1'b1;
                err0_d = fin_err;
                if (fin_rd) rdata0_d = fin_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= 16'h0;
            rdata1_q     <= 16'h0;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_bsel_q     <= 1'b0;
            m_addr_q     <= 16'h0;
            m_wdata_q    <= 16'h0;
        end else begin
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
            m_bsel_q     <= m_bsel_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_bsel  = m_bsel_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

    // mmio decodes writes from write_enable alone, so m_we needs m_en.
    a_we_en:    assert property (@(posedge clk) m_we_q |-> m_en_q);
    a_ack_excl: assert property (@(posedge clk) !(ack0_q && ack1_q));
    a_rst_ack:  assert property (@(posedge clk) rst |=> !(ack0_q || ack1_q));

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter with a small mmio responder and a
// transaction-level schedule model of the arbiter.
module tb_mmio_arbiter;
    import mmio_arbiter_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int NCYC    = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, bsel0, bsel1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic        m_en, m_we, m_bsel;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata;
    logic        m_serviced;
    logic        stray;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    logic        mdl_last;
    logic [15:0] mdl_rd0, mdl_rd1;

    logic        e_ack0 [NCYC];
    logic        e_ack1 [NCYC];
    logic        e_en   [NCYC];
    logic        e_we   [NCYC];
    logic        e_bsel [NCYC];
    logic        e_err  [NCYC];
    logic [15:0] e_addr [NCYC];
    logic [15:0] e_wd   [NCYC];
    logic [15:0] e_rd0  [NCYC];
    logic [15:0] e_rd1  [NCYC];

    always #5 clk = ~clk;

    mmio_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .bsel0(bsel0), .bsel1(bsel1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .m_en(m_en), .m_we(m_we), .m_bsel(m_bsel), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_serviced(m_serviced)
    );

    function automatic logic [15:0] mmio_val(input logic [15:0] ra);
        return (ra == 16'hFF03) ? 16'h0040 : (ra ^ 16'hA5C3);
    endfunction

    // mmio responder: answers reads at or above the base one cycle after en.
    always @(posedge clk) begin
        if (stray) begin
            m_serviced <= 1'b1;
            m_rdata    <= 16'hBEEF;
        end else if (m_en && !m_we && real_addr(m_addr, m_bsel) >= MMIO_BASE) begin
            m_serviced <= 1'b1;
            m_rdata    <= mmio_val(real_addr(m_addr, m_bsel));
        end else begin
            m_serviced <= 1'b0;
            m_rdata    <= 16'h0;
        end
        if (m_en && m_we && real_addr(m_addr, m_bsel) == MMIO_BASE)
            led <= m_wdata[7:0];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rnd_addr();
        logic [15:0] a;
        a = 16'($urandom);
        if ($urandom_range(0, 1) == 1) a[14:7] = 8'hFF;
        return a;
    endfunction

    // Master x issues nx identical ops, holding req until its last ack.
    task automatic run_ops(
        input int n0, input int n1,
        input logic w0, input logic w1,
        input logic [15:0] a0, input logic [15:0] a1,
        input logic b0, input logic b1,
        input logic [15:0] d0, input logic [15:0] d1
    );
        int t, prev, r0, r1, g, dur, fin, last0, last1;
        logic e0, e1, gw, gb, ok;
        logic [15:0] ga, gd;
        for (int c = 0; c < NCYC; c++) begin
            e_ack0[c] = 1'b0; e_ack1[c] = 1'b0; e_en[c] = 1'b0;
            e_we[c] = 1'b0; e_bsel[c] = 1'b0; e_err[c] = 1'b0;
            e_addr[c] = 16'h0; e_wd[c] = 16'h0;
            e_rd0[c] = 16'h0; e_rd1[c] = 16'h0;
        end
        t = 0; prev = -1; r0 = n0; r1 = n1;
        last0 = -1; last1 = -1; fin = 0;
        while (r0 > 0 || r1 > 0) begin
            e0 = (r0 > 0) && (prev != 0);
            e1 = (r1 > 0) && (prev != 1);
            if (!e0 && !e1) begin
                t++;
                prev = -1;
                continue;
            end
            g  = (e0 && e1) ? (mdl_last ? 0 : 1) : (e1 ? 1 : 0);
            gw = (g == 1) ? w1 : w0;
            ga = (g == 1) ? a1 : a0;
            gb = (g == 1) ? b1 : b0;
            gd = (g == 1) ? d1 : d0;
            ok = real_addr(ga, gb) >= MMIO_BASE;
            dur = gw ? 2 : (ok ? 3 : 2 + TIMEOUT);
            e_en[t+1] = 1'b1; e_we[t+1] = gw; e_addr[t+1] = ga;
            e_bsel[t+1] = gb; e_wd[t+1] = gd;
            if (!gw) begin
                if (g == 0) mdl_rd0 = ok ? mmio_val(real_addr(ga, gb)) : 16'h0;
                else        mdl_rd1 = ok ? mmio_val(real_addr(ga, gb)) : 16'h0;
            end
            e_err[t+dur] = !gw && !ok;
            if (g == 0) begin e_ack0[t+dur] = 1'b1; r0--; last0 = t + dur; end
            else        begin e_ack1[t+dur] = 1'b1; r1--; last1 = t + dur; end
            e_rd0[t+dur] = mdl_rd0;
            e_rd1[t+dur] = mdl_rd1;
            mdl_last = (g == 1);
            prev = g;
            t = t + dur;
            fin = t;
        end
        @(negedge clk);
        req0 = (n0 > 0); req1 = (n1 > 0);
        we0 = w0; we1 = w1; addr0 = a0; addr1 = a1;
        bsel0 = b0; bsel1 = b1; wdata0 = d0; wdata1 = d1;
        for (int c = 1; c <= fin; c++) begin
            @(negedge clk);
            chk("ack0", {15'h0, ack0}, {15'h0, e_ack0[c]});
            chk("ack1", {15'h0, ack1}, {15'h0, e_ack1[c]});
            chk("m_en", {15'h0, m_en}, {15'h0, e_en[c]});
            chk("m_we", {15'h0, m_we}, {15'h0, e_we[c]});
            chk("m_addr", m_addr, e_addr[c]);
            if (e_en[c]) begin
                chk("m_bsel", {15'h0, m_bsel}, {15'h0, e_bsel[c]});
                chk("m_wdata", m_wdata, e_wd[c]);
            end
            if (e_ack0[c]) chk("err0", {15'h0, err0}, {15'h0, e_err[c]});
            if (e_ack1[c]) chk("err1", {15'h0, err1}, {15'h0, e_err[c]});
            if (e_ack0[c] || e_ack1[c]) begin
                chk("rdata0", rdata0, e_rd0[c]);
                chk("rdata1", rdata1, e_rd1[c]);
            end
            if (c == last0) req0 = 1'b0;
            if (c == last1) req1 = 1'b0;
        end
    endtask

    initial begin
        int n0, n1;
        rst = 1'b1; stray = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; bsel0 = 0; bsel1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {14'h0, ack1, ack0}, 16'h0);
        chk("rst_err", {14'h0, err1, err0}, 16'h0);
        chk("rst_rdata0", rdata0, 16'h0);
        chk("rst_rdata1", rdata1, 16'h0);
        chk("rst_men", {14'h0, m_we, m_en}, 16'h0);
        chk("rst_maddr", m_addr, 16'h0);
        rst = 1'b0;
        mdl_last = 1'b1; mdl_rd0 = 16'h0; mdl_rd1 = 16'h0;

        // LED write from master 0
        run_ops(1, 0, 1, 0, 16'h7F80, 16'h0, 0, 0, 16'h00A5, 16'h0);
        chk("led", {8'h0, led}, 16'h00A5);

        // UART status read from master 1, then rdata hold
        run_ops(0, 1, 0, 0, 16'h0, 16'h7F81, 0, 1, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        chk("rdata1_hold", rdata1, 16'h0040);

        // unserviced read times out
        run_ops(1, 0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);

        // both masters streaming writes alternate
        run_ops(4, 4, 1, 1, 16'h7F90, 16'h1234, 1, 0, 16'h1111, 16'h2222);

        // reset in RD_WAIT while mmio answers
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 16'h7F81; bsel1 = 1;
        @(negedge clk);
        chk("rst5_men", {15'h0, m_en}, 16'h1);
        @(negedge clk);
        rst = 1'b1; req1 = 1'b0;
        @(negedge clk);
        chk("rst5_ack", {14'h0, ack1, ack0}, 16'h0);
        chk("rst5_men", {14'h0, m_we, m_en}, 16'h0);
        chk("rst5_rdata1", rdata1, 16'h0);
        rst = 1'b0;
        mdl_last = 1'b1; mdl_rd0 = 16'h0; mdl_rd1 = 16'h0;
        @(negedge clk);
        chk("rst5_noack", {14'h0, ack1, ack0}, 16'h0);

        // stray serviced pulse in IDLE
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_ack", {14'h0, ack1, ack0}, 16'h0);
        chk("stray_rdata0", rdata0, 16'h0);
        chk("stray_rdata1", rdata1, 16'h0);

        // req0 dropped right after grant still completes
        req0 = 1; we0 = 1; addr0 = 16'h0042; bsel0 = 0; wdata0 = 16'h5555;
        @(negedge clk);
        chk("drop_men", {15'h0, m_en}, 16'h1);
        req0 = 1'b0;
        @(negedge clk);
        chk("drop_ack", {15'h0, ack0}, 16'h1);
        @(negedge clk);
        chk("drop_once", {14'h0, ack1, ack0}, 16'h0);
        mdl_last = 1'b0;

        // randomized traffic against the schedule model
        repeat (30) begin
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 == 0 && n1 == 0) n0 = 1;
            run_ops(n0, n1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    rnd_addr(), rnd_addr(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
